// File: rtl/error_sum_accumulator_pkg.sv
// Shared constants, FSM state type and log-record layout for the error-sum accumulator.
package error_sum_accumulator_pkg;

    localparam int NUM_OUTPUTS    = 8;
    localparam int COUNTER_WIDTH  = 32;
    localparam int MEM_ADDR_WIDTH = 15;
    localparam int RECORD_WIDTH   = 32;

    // Byte lanes of one log record
    localparam int MISMATCH_LSB = 24;
    localparam int VALID_LSB    = 16;
    localparam int EXPECTED_LSB = 8;
    localparam int CHROM_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DONE
    } state_t;

    // Assemble one log record from the stage-1 sample fields
    function automatic logic [RECORD_WIDTH-1:0] pack_record(
        input logic [NUM_OUTPUTS-1:0] mismatch,
        input logic [NUM_OUTPUTS-1:0] valid,
        input logic [NUM_OUTPUTS-1:0] expected,
        input logic [NUM_OUTPUTS-1:0] chrom
    );
        logic [RECORD_WIDTH-1:0] rec;
        rec = '0;
        rec[MISMATCH_LSB +: NUM_OUTPUTS] = mismatch;
        rec[VALID_LSB    +: NUM_OUTPUTS] = valid;
        rec[EXPECTED_LSB +: NUM_OUTPUTS] = expected;
        rec[CHROM_LSB    +: NUM_OUTPUTS] = chrom;
        return rec;
    endfunction

endpackage

// File: rtl/error_sum_accumulator_if.sv
// Sample, handshake and log-RAM signals of the error-sum accumulator.
interface error_sum_accumulator_if;
    import error_sum_accumulator_pkg::*;

    logic                                   iStart;
    logic                                   iSampleValid;
    logic                                   iLastSample;
    logic [NUM_OUTPUTS-1:0]                 iChromOutput;
    logic [NUM_OUTPUTS-1:0]                 iExpectedOutput;
    logic [NUM_OUTPUTS-1:0]                 iValidOutput;
    logic                                   iDoneFeedback;
    logic                                   oBusy;
    logic                                   oDone;
    logic [NUM_OUTPUTS*COUNTER_WIDTH-1:0]   oErrorSums;
    logic [MEM_ADDR_WIDTH-1:0]              oMemAddr;
    logic [RECORD_WIDTH-1:0]                oMemWriteData;
    logic                                   oWriteToMem;
    logic                                   oMemOverflow;
    logic [15:0]                            oSampleCount;

    // Upstream evaluation control / HPS side
    modport master (
        output iStart, iSampleValid, iLastSample, iChromOutput,
               iExpectedOutput, iValidOutput, iDoneFeedback,
        input  oBusy, oDone, oErrorSums, oMemAddr, oMemWriteData,
               oWriteToMem, oMemOverflow, oSampleCount
    );

    // Accumulator side
    modport slave (
        input  iStart, iSampleValid, iLastSample, iChromOutput,
               iExpectedOutput, iValidOutput, iDoneFeedback,
        output oBusy, oDone, oErrorSums, oMemAddr, oMemWriteData,
               oWriteToMem, oMemOverflow, oSampleCount
    );

endinterface

// File: rtl/error_sum_accumulator_sat_counter.sv
// Single error counter: clear, increment, holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    // Count up on inc until saturated; clear has priority over inc
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/error_sum_accumulator.sv
// Per-bit saturating error counters over a sample stream, with a per-sample
// mismatch log written to on-chip RAM and a done/feedback handshake.
module error_sum_accumulator
    import error_sum_accumulator_pkg::*;
#(
    parameter int MEM_BASE_ADDR = 0,
    parameter int MEM_LAST_ADDR = 32767
) (
    input  logic                  iClock,
    input  logic                  iReset,
    error_sum_accumulator_if.slave bus
);

    localparam logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = MEM_ADDR_WIDTH'(MEM_BASE_ADDR);
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_LAST_ADDR);

    state_t                               state_reg, state_next;
    logic                                 busy, done;
    logic                                 start_accept, strobe, mem_full;

    logic                                 s1_valid_reg;
    logic [NUM_OUTPUTS-1:0]               chrom_reg, expected_reg, valid_reg, mismatch_reg;

    logic                                 write_reg;
    logic [RECORD_WIDTH-1:0]              wdata_reg;
    logic [MEM_ADDR_WIDTH-1:0]            addr_reg;
    logic                                 overflow_reg;
    logic [15:0]                          sample_count_reg;
    logic [NUM_OUTPUTS*COUNTER_WIDTH-1:0] error_sums;

    assign start_accept = (state_reg == IDLE)  && bus.iStart;
    assign strobe       = (state_reg == ACCUM) && bus.iSampleValid;
    // The write currently on the bus at LAST_ADDR already exhausts the log
    assign mem_full     = overflow_reg || (write_reg && (addr_reg == LAST_ADDR));

    // FSM state register
    always_ff @(posedge iClock) begin
        if (iReset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM next state and status outputs
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE:  if (bus.iStart) state_next = ACCUM;
            ACCUM: begin
                busy = 1'b1;
                if (bus.iSampleValid && bus.iLastSample) state_next = FLUSH;
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.iDoneFeedback) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: capture the sample and its masked mismatch vector
    always_ff @(posedge iClock) begin
        if (iReset) begin
            s1_valid_reg <= 1'b0;
            chrom_reg    <= '0;
            expected_reg <= '0;
            valid_reg    <= '0;
            mismatch_reg <= '0;
        end else begin
            s1_valid_reg <= strobe;
            if (strobe) begin
                chrom_reg    <= bus.iChromOutput;
                expected_reg <= bus.iExpectedOutput;
                valid_reg    <= bus.iValidOutput;
                mismatch_reg <= bus.iValidOutput & (bus.iChromOutput ^ bus.iExpectedOutput);
            end
        end
    end

    // Stage 2 log: one write per retired sample, address advances after each write
    always_ff @(posedge iClock) begin
        if (iReset) begin
            write_reg    <= 1'b0;
            wdata_reg    <= '0;
            addr_reg     <= BASE_ADDR;
            overflow_reg <= 1'b0;
        end else begin
            write_reg <= s1_valid_reg && !mem_full;
            if (s1_valid_reg && !mem_full) begin
                wdata_reg <= pack_record(mismatch_reg, valid_reg, expected_reg, chrom_reg);
            end
            if (start_accept) begin
                addr_reg     <= BASE_ADDR;
                overflow_reg <= 1'b0;
            end else if (write_reg) begin
                if (addr_reg == LAST_ADDR) overflow_reg <= 1'b1;
                else                       addr_reg     <= addr_reg + MEM_ADDR_WIDTH'(1);
            end
        end
    end

    // Accepted-sample counter, wraps freely
    always_ff @(posedge iClock) begin
        if (iReset || start_accept) sample_count_reg <= '0;
        else if (strobe)            sample_count_reg <= sample_count_reg + 16'd1;
    end

    // One saturating counter per output bit, fed by the stage-1 mismatch vector
    generate
        for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : gen_counter
            sat_counter #(
                .WIDTH (COUNTER_WIDTH)
            ) u_counter (
                .clk   (iClock),
                .srst  (iReset),
                .clear (start_accept),
                .inc   (s1_valid_reg && mismatch_reg[gi]),
                .count (error_sums[gi*COUNTER_WIDTH +: COUNTER_WIDTH])
            );
        end
    endgenerate

    assign bus.oBusy         = busy;
    assign bus.oDone         = done;
    assign bus.oErrorSums    = error_sums;
    assign bus.oMemAddr      = addr_reg;
    assign bus.oMemWriteData = wdata_reg;
    assign bus.oWriteToMem   = write_reg;
    assign bus.oMemOverflow  = overflow_reg;
    assign bus.oSampleCount  = sample_count_reg;

endmodule
